// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch/decode/execute strobes for the simple RISC datapath.
// Define CTRL_HALT_EN to build the HALT state for opcode 111; otherwise 111 runs as a NOP.
module cpu_controller #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] ir_i,
  output logic        loadpc_o,
  output logic        resetpc_o,
  output logic        msel_o,
  output logic        mwrite_o,
  output logic        loadir_o,
  output logic        loadaddr_o,
  output logic [2:0]  nsel_o,
  output logic [1:0]  vsel_o,
  output logic        write_o,
  output logic        loada_o,
  output logic        loadb_o,
  output logic        asel_o,
  output logic        bsel_o,
  output logic        loadc_o,
  output logic        loads_o,
  output logic        halted_o
);
  typedef enum logic [4:0] {
    RST, IF1, IF2, UPD, DEC, WBI, GA, GB, ALUM, ALU, WB, CMPS,
    ADR, LA, MEM_RD, WBM, GBD, MVB, MEM_WR
`ifdef CTRL_HALT_EN
    , HALT
`endif
  } state_e;
  localparam logic [4:0] K_MOVI = 5'b11010, K_MOV = 5'b11000, K_MVN = 5'b10111,
                         K_ADD = 5'b10100, K_AND = 5'b10110, K_CMP = 5'b10101,
                         K_LDR = 5'b01100, K_STR = 5'b10000;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] key;
  logic wait_done;
  logic unused_ir;
  assign key = ir_i[15:11];
  assign wait_done = cnt_q == 3'(MEM_WAIT - 1);
  // register fields are consumed by the datapath, not the sequencer
  assign unused_ir = ^ir_i[10:0];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= RST;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = IF1;
    cnt_d = '0;
    case (state_q)
      IF1: begin
        state_d = wait_done ? IF2 : IF1;
        cnt_d = wait_done ? 3'd0 : cnt_q + 3'd1;
      end
      IF2: state_d = UPD;
      UPD: state_d = DEC;
      DEC:
        case (key) inside
          K_MOVI: state_d = WBI;
          K_MOV, K_MVN: state_d = GB;
          K_ADD, K_AND, K_CMP, K_LDR, K_STR: state_d = GA;
`ifdef CTRL_HALT_EN
          5'b111??: state_d = HALT;
`endif
          default: state_d = IF1;
        endcase
      GA: state_d = (key == K_LDR || key == K_STR) ? ADR : GB;
      GB: state_d = (key == K_MOV || key == K_MVN) ? ALUM : key == K_CMP ? CMPS : ALU;
      ALUM, ALU: state_d = WB;
      ADR: state_d = LA;
      LA: state_d = key == K_LDR ? MEM_RD : GBD;
      MEM_RD: begin
        state_d = wait_done ? WBM : MEM_RD;
        cnt_d = wait_done ? 3'd0 : cnt_q + 3'd1;
      end
      GBD: state_d = MVB;
      MVB: state_d = MEM_WR;
`ifdef CTRL_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = IF1;
    endcase
  end
  assign loadpc_o = state_q inside {RST, UPD};
  assign resetpc_o = state_q == RST;
  assign msel_o = state_q inside {IF1, IF2, MEM_RD, MEM_WR};
  assign mwrite_o = state_q == MEM_WR;
  assign loadir_o = state_q == IF2;
  assign loadaddr_o = state_q == LA;
  assign nsel_o = {state_q == GB, state_q inside {WB, WBM, GBD}, state_q inside {GA, WBI}};
  assign vsel_o = {state_q == WBM, state_q == WBI};
  assign write_o = state_q inside {WBI, WB, WBM};
  assign loada_o = state_q == GA;
  assign loadb_o = state_q inside {GB, GBD};
  assign asel_o = state_q inside {ALUM, MVB};
  assign bsel_o = state_q == ADR;
  assign loadc_o = state_q inside {ALUM, ALU, ADR, MVB};
  assign loads_o = state_q == CMPS;
`ifdef CTRL_HALT_EN
  assign halted_o = state_q == HALT;
`else
  assign halted_o = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: runs two controllers (MEM_WAIT 1 and 3) against per-cycle expected strobe vectors.
module tb_cpu_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] ir [2];
  logic loadpc [2], resetpc [2], msel [2], mwrite [2], loadir [2], loadaddr [2];
  logic write [2], loada [2], loadb [2], asel [2], bsel [2], loadc [2], loads [2], halted [2];
  logic [2:0] nsel [2];
  logic [1:0] vsel [2];
  logic [18:0] q0 [$];
  logic [18:0] q1 [$];
  int checks = 0;
  int errors = 0;
  localparam logic [18:0] V_RST  = {6'b110000, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_IF1  = {6'b001000, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_IF2  = {6'b001010, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_UPD  = {6'b100000, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_DEC  = {6'b000000, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_WBI  = {6'b000000, 3'b001, 2'b01, 8'b10000000};
  localparam logic [18:0] V_GA   = {6'b000000, 3'b001, 2'b00, 8'b01000000};
  localparam logic [18:0] V_GB   = {6'b000000, 3'b100, 2'b00, 8'b00100000};
  localparam logic [18:0] V_ALUM = {6'b000000, 3'b000, 2'b00, 8'b00010100};
  localparam logic [18:0] V_ALU  = {6'b000000, 3'b000, 2'b00, 8'b00000100};
  localparam logic [18:0] V_WB   = {6'b000000, 3'b010, 2'b00, 8'b10000000};
  localparam logic [18:0] V_CMP  = {6'b000000, 3'b000, 2'b00, 8'b00000010};
  localparam logic [18:0] V_ADR  = {6'b000000, 3'b000, 2'b00, 8'b00001100};
  localparam logic [18:0] V_LA   = {6'b000001, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_MRD  = {6'b001000, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_WBM  = {6'b000000, 3'b010, 2'b10, 8'b10000000};
  localparam logic [18:0] V_GBD  = {6'b000000, 3'b010, 2'b00, 8'b00100000};
  localparam logic [18:0] V_MVB  = {6'b000000, 3'b000, 2'b00, 8'b00010100};
  localparam logic [18:0] V_MWR  = {6'b001100, 3'b000, 2'b00, 8'b00000000};
  localparam logic [18:0] V_HALT = {6'b000000, 3'b000, 2'b00, 8'b00000001};
  localparam logic [15:0] PROG [11] = '{16'hD007, 16'hC061, 16'hB862, 16'hA148, 16'hB148,
                                         16'hA900, 16'h8123, 16'h6040, 16'hC800, 16'hE000, 16'h0000};
`ifdef CTRL_HALT_EN
  localparam int NP = 10;
`else
  localparam int NP = 11;
`endif
  always #5 clk = ~clk;
  cpu_controller #(.MEM_WAIT(1)) u_w1 (
    .clk_i(clk), .rst_ni(rst_n), .ir_i(ir[0]), .loadpc_o(loadpc[0]), .resetpc_o(resetpc[0]),
    .msel_o(msel[0]), .mwrite_o(mwrite[0]), .loadir_o(loadir[0]), .loadaddr_o(loadaddr[0]),
    .nsel_o(nsel[0]), .vsel_o(vsel[0]), .write_o(write[0]), .loada_o(loada[0]), .loadb_o(loadb[0]),
    .asel_o(asel[0]), .bsel_o(bsel[0]), .loadc_o(loadc[0]), .loads_o(loads[0]), .halted_o(halted[0])
  );
  cpu_controller #(.MEM_WAIT(3)) u_w3 (
    .clk_i(clk), .rst_ni(rst_n), .ir_i(ir[1]), .loadpc_o(loadpc[1]), .resetpc_o(resetpc[1]),
    .msel_o(msel[1]), .mwrite_o(mwrite[1]), .loadir_o(loadir[1]), .loadaddr_o(loadaddr[1]),
    .nsel_o(nsel[1]), .vsel_o(vsel[1]), .write_o(write[1]), .loada_o(loada[1]), .loadb_o(loadb[1]),
    .asel_o(asel[1]), .bsel_o(bsel[1]), .loadc_o(loadc[1]), .loads_o(loads[1]), .halted_o(halted[1])
  );
  function automatic logic [18:0] obs(input int d);
    return {loadpc[d], resetpc[d], msel[d], mwrite[d], loadir[d], loadaddr[d], nsel[d], vsel[d],
            write[d], loada[d], loadb[d], asel[d], bsel[d], loadc[d], loads[d], halted[d]};
  endfunction
  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic push(input int d, input logic [18:0] v);
    if (d == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask
  task automatic gen(input int d, input logic [15:0] i);
    int w;
    logic [4:0] k;
    w = d == 0 ? 1 : 3;
    k = i[15:11];
    for (int n = 0; n < w; n++) push(d, V_IF1);
    push(d, V_IF2);
    push(d, V_UPD);
    push(d, V_DEC);
    if (k == 5'b11010) push(d, V_WBI);
    else if (k == 5'b11000 || k == 5'b10111) begin
      push(d, V_GB); push(d, V_ALUM); push(d, V_WB);
    end else if (k == 5'b10100 || k == 5'b10110) begin
      push(d, V_GA); push(d, V_GB); push(d, V_ALU); push(d, V_WB);
    end else if (k == 5'b10101) begin
      push(d, V_GA); push(d, V_GB); push(d, V_CMP);
    end else if (k == 5'b01100) begin
      push(d, V_GA); push(d, V_ADR); push(d, V_LA);
      for (int n = 0; n < w; n++) push(d, V_MRD);
      push(d, V_WBM);
    end else if (k == 5'b10000) begin
      push(d, V_GA); push(d, V_ADR); push(d, V_LA); push(d, V_GBD); push(d, V_MVB); push(d, V_MWR);
    end
`ifdef CTRL_HALT_EN
    else if (i[15:13] == 3'b111) for (int n = 0; n < 20; n++) push(d, V_HALT);
`endif
  endtask
  initial begin
    int pc [2];
    bit done [2];
    logic [18:0] exp;
    pc[0] = 0; pc[1] = 0; done[0] = 0; done[1] = 0;
    ir[0] = 16'h0000;
    ir[1] = 16'h0000;
    @(negedge clk);
    check("reset_w1", obs(0), V_RST);
    check("reset_w3", obs(1), V_RST);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold_w1", obs(0), V_RST);
    check("rst_hold_w3", obs(1), V_RST);
    @(negedge clk);
    check("if1_w1", obs(0), V_IF1);
    check("if1_w3", obs(1), V_IF1);
    @(negedge clk);
    check("if2_w1", obs(0), V_IF2);
    check("if1_wait_w3", obs(1), V_IF1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_w1", obs(0), V_RST);
    check("async_rst_w3", obs(1), V_RST);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_w1", obs(0), V_RST);
    check("rst_rel_w3", obs(1), V_RST);
    for (int c = 0; c < 2000 && !(done[0] && done[1]); c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!done[d] && (d == 0 ? q0.size() : q1.size()) == 0) begin
          if (pc[d] < NP) begin
            ir[d] = PROG[pc[d]];
            gen(d, PROG[pc[d]]);
            pc[d]++;
          end else done[d] = 1;
        end
        if (!done[d]) begin
          exp = d == 0 ? q0.pop_front() : q1.pop_front();
          check($sformatf("w%0d_ir_%h", d == 0 ? 1 : 3, ir[d]), obs(d), exp);
        end
      end
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout: program not completed, pc %0d/%0d required %0d", pc[0], pc[1], NP);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
